// File: rtl/hc_pkg.sv
// hc_pkg: shared types for the CCI-P c0 read arbiter.
//   hc_addr_t       42-bit cache-line address
//   hc_mdata_t      16-bit c0 request/response metadata tag
//   hc_arb_state_e  arbiter flush FSM state
//   hc_mdata_of()   builds the metadata tag carrying a requester index
package hc_pkg;

    localparam int unsigned HC_ADDR_W  = 42;
    localparam int unsigned HC_MDATA_W = 16;
    // Low mdata bits carry the requester index (up to 8 requesters)
    localparam int unsigned HC_IDX_W   = 3;

    typedef logic [HC_ADDR_W-1:0]  hc_addr_t;
    typedef logic [HC_MDATA_W-1:0] hc_mdata_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } hc_arb_state_e;

    // Zero-extend a requester index into a metadata tag
    function automatic hc_mdata_t hc_mdata_of(input logic [HC_IDX_W-1:0] idx);
        return HC_MDATA_W'(idx);
    endfunction

endpackage

// File: rtl/hc_rr_pick.sv
// hc_rr_pick: combinational round-robin picker.
//   N, PW    number of requesters and pointer width
//   req_i    request vector
//   ptr_i    index with highest priority this cycle
//   grant_o  one-hot grant of the first set request at or after ptr_i, wrapping
module hc_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan from ptr_i upward modulo N, first hit wins
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hc_rd_arbiter.sv
// hc_rd_arbiter: round-robin arbiter of N_REQ read requesters onto the CCI-P c0
// request channel, with outstanding-read accounting, response routing and flush.
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_addr    per-requester pending read and cache-line address
//   req_grant             one-hot acceptance this cycle (combinational)
//   c0_tx_valid/addr/mdata registered c0 read request, mdata = requester index
//   c0_tx_almfull         c0 back-pressure
//   c0_rx_rdvalid/mdata   read response; routed to rsp_valid (combinational)
//   flush/flush_done      drain request and its completion
//   grant_count           per-requester saturating grant counters, present only
//                         when HC_RD_ARB_STATS_EN is defined
module hc_rd_arbiter
    import hc_pkg::*;
#(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  hc_addr_t [N_REQ-1:0]  req_addr,
    output logic [N_REQ-1:0]      req_grant,
    output logic                  c0_tx_valid,
    output hc_addr_t              c0_tx_addr,
    output hc_mdata_t             c0_tx_mdata,
    input  logic                  c0_tx_almfull,
    input  logic                  c0_rx_rdvalid,
    input  hc_mdata_t             c0_rx_mdata,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic                  flush,
    output logic                  flush_done
`ifdef HC_RD_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0] grant_count
`endif
);

    localparam int unsigned PW = $clog2(N_REQ);
    // One extra bit so the counter can hold MAX_OUTSTANDING itself
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

    hc_arb_state_e        state_q;
    logic                 flush_done_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [OW-1:0]        outstanding_q, outstanding_d;
    logic [N_REQ-1:0]     pick_oh;
    logic [PW-1:0]        gidx;
    logic                 grant_any;
    logic                 grant_ok;
    logic                 room;
    logic [HC_IDX_W-1:0]  rsp_idx;
    logic                 rsp_hit;
    logic                 rsp_dec;
    logic                 drain_empty;
    logic                 unused_mdata_hi;

    hc_rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_oh)
    );

    // Response decode: only the low index bits matter, out-of-range tags are dropped
    assign rsp_idx         = c0_rx_mdata[HC_IDX_W-1:0];
    assign unused_mdata_hi = ^c0_rx_mdata[HC_MDATA_W-1:HC_IDX_W];
    assign rsp_hit         = c0_rx_rdvalid && (32'(rsp_idx) < N_REQ);
    // Saturate at zero: stray responses after a reset never underflow
    assign rsp_dec         = rsp_hit && (outstanding_q != '0);

    // A response retiring this cycle frees a slot for a same-cycle grant
    assign room     = (32'(outstanding_q) < MAX_OUTSTANDING) || rsp_dec;
    assign grant_ok = reset_n && (state_q == ST_RUN) && !c0_tx_almfull && room;

    assign req_grant = grant_ok ? pick_oh : '0;
    assign grant_any = |req_grant;

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_grant[i]) gidx = PW'(i);
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = reset_n && rsp_hit && (32'(rsp_idx) == i);
        end
    end

    // Grant and retire in the same cycle cancel out
    always_comb begin
        outstanding_d = outstanding_q;
        if (grant_any && !rsp_dec) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!grant_any && rsp_dec) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    // Drain completes once nothing is in flight after this cycle's retirement
    assign drain_empty = (outstanding_d == '0) && !c0_tx_valid;

    // Datapath: pointer, accounting and registered c0 issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            c0_tx_valid   <= 1'b0;
            c0_tx_addr    <= '0;
            c0_tx_mdata   <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            c0_tx_valid   <= grant_any;
            if (grant_any) begin
                rr_ptr_q    <= PW'((32'(gidx) + 1) % N_REQ);
                c0_tx_addr  <= req_addr[gidx];
                c0_tx_mdata <= hc_mdata_of(HC_IDX_W'(gidx));
            end
        end
    end

    // Flush FSM with registered completion flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (flush) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state_q      <= ST_DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!flush) begin
                        state_q      <= ST_RUN;
                        flush_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_RUN;
                    flush_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush_done = flush_done_q;

`ifdef HC_RD_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] grant_cnt_q;

    // Per-requester grant counters, saturating at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req_grant[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign grant_count = grant_cnt_q;
`endif

endmodule

// File: tb/tb_hc_rd_arbiter.sv
// tb_hc_rd_arbiter: directed bench for hc_rd_arbiter. u_dut runs with
// MAX_OUTSTANDING=4 for the capacity scenarios; u_big keeps the default depth
// so a five-grant round-robin sequence is not capacity limited.
module tb_hc_rd_arbiter;
    import hc_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [3:0]          req_valid = '0;
    hc_addr_t [3:0]      req_addr;
    logic                almfull = 1'b0;
    logic                rdvalid = 1'b0;
    hc_mdata_t           rx_mdata = '0;
    logic                flush = 1'b0;

    logic [3:0]          grant_a, rsp_a, grant_b, rsp_b;
    logic                tx_valid_a, fdone_a, tx_valid_b, fdone_b;
    hc_addr_t            tx_addr_a, tx_addr_b;
    hc_mdata_t           tx_mdata_a, tx_mdata_b;
`ifdef HC_RD_ARB_STATS_EN
    logic [3:0][31:0]    gcnt_a, gcnt_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hc_rd_arbiter #(.N_REQ(4), .MAX_OUTSTANDING(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_grant(grant_a), .c0_tx_valid(tx_valid_a), .c0_tx_addr(tx_addr_a),
        .c0_tx_mdata(tx_mdata_a), .c0_tx_almfull(almfull), .c0_rx_rdvalid(rdvalid),
        .c0_rx_mdata(rx_mdata), .rsp_valid(rsp_a), .flush(flush), .flush_done(fdone_a)
`ifdef HC_RD_ARB_STATS_EN
        , .grant_count(gcnt_a)
`endif
    );

    hc_rd_arbiter #(.N_REQ(4)) u_big (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_grant(grant_b), .c0_tx_valid(tx_valid_b), .c0_tx_addr(tx_addr_b),
        .c0_tx_mdata(tx_mdata_b), .c0_tx_almfull(almfull), .c0_rx_rdvalid(rdvalid),
        .c0_rx_mdata(rx_mdata), .rsp_valid(rsp_b), .flush(flush), .flush_done(fdone_b)
`ifdef HC_RD_ARB_STATS_EN
        , .grant_count(gcnt_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        almfull   = 1'b0;
        rdvalid   = 1'b0;
        rx_mdata  = '0;
        flush     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        rdvalid   = 1'b1;
        rx_mdata  = 16'd1;
        tick();
        tick();
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL reset_grant_a: got %b expected 0000", grant_a); end
        n_checks++; if (tx_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_txvalid_a: got %b expected 0", tx_valid_a); end
        n_checks++; if (rsp_a !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_a: got %b expected 0000", rsp_a); end
        n_checks++; if (fdone_a !== 1'b0) begin n_fail++; $display("FAIL reset_fdone_a: got %b expected 0", fdone_a); end
        n_checks++; if (grant_b !== 4'b0000) begin n_fail++; $display("FAIL reset_grant_b: got %b expected 0000", grant_b); end
        n_checks++; if (tx_valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_txvalid_b: got %b expected 0", tx_valid_b); end
        apply_reset();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        apply_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'(1 << (k % 4));
            #1;
            n_checks++; if (grant_b !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, grant_b, exp_g); end
            tick();
            n_checks++; if (tx_valid_b !== 1'b1) begin n_fail++; $display("FAIL rr_txvalid%0d: got %b expected 1", k, tx_valid_b); end
            n_checks++; if (tx_mdata_b !== 16'(k % 4)) begin n_fail++; $display("FAIL rr_mdata%0d: got %0d expected %0d", k, tx_mdata_b, k % 4); end
            n_checks++; if (tx_addr_b !== req_addr[2'(k % 4)]) begin n_fail++; $display("FAIL rr_addr%0d: got %h expected %h", k, tx_addr_b, req_addr[2'(k % 4)]); end
        end
        req_valid = '0;
        tick();
        n_checks++; if (tx_valid_b !== 1'b0) begin n_fail++; $display("FAIL rr_idle_txvalid: got %b expected 0", tx_valid_b); end
    endtask

    task automatic test_almfull();
        apply_reset();
        req_valid = 4'b0001;
        almfull   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL almfull_grant%0d: got %b expected 0000", k, grant_a); end
            tick();
        end
        almfull = 1'b0;
        #1;
        n_checks++; if (grant_a !== 4'b0001) begin n_fail++; $display("FAIL almfull_release_grant: got %b expected 0001", grant_a); end
        tick();
        n_checks++; if (tx_valid_a !== 1'b1) begin n_fail++; $display("FAIL almfull_txvalid: got %b expected 1", tx_valid_a); end
        n_checks++; if (tx_mdata_a !== 16'd0) begin n_fail++; $display("FAIL almfull_mdata: got %0d expected 0", tx_mdata_a); end
        req_valid = '0;
    endtask

    task automatic test_max_outstanding();
        apply_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (grant_a !== 4'(1 << k)) begin n_fail++; $display("FAIL max_fill_grant%0d: got %b expected %b", k, grant_a, 4'(1 << k)); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL max_full_grant%0d: got %b expected 0000", k, grant_a); end
            tick();
        end
        rdvalid  = 1'b1;
        rx_mdata = 16'd2;
        #1;
        n_checks++; if (rsp_a !== 4'b0100) begin n_fail++; $display("FAIL max_rsp: got %b expected 0100", rsp_a); end
        n_checks++; if (grant_a !== 4'b0001) begin n_fail++; $display("FAIL max_rsp_grant: got %b expected 0001", grant_a); end
        tick();
        rdvalid = 1'b0;
        #1;
        n_checks++; if (tx_valid_a !== 1'b1 || tx_mdata_a !== 16'd0) begin n_fail++; $display("FAIL max_reissue: got valid=%b mdata=%0d expected valid=1 mdata=0", tx_valid_a, tx_mdata_a); end
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL max_refull_grant: got %b expected 0000", grant_a); end
        // Out-of-range tag: no routing and no slot freed
        rdvalid  = 1'b1;
        rx_mdata = 16'd6;
        #1;
        n_checks++; if (rsp_a !== 4'b0000) begin n_fail++; $display("FAIL drop_rsp: got %b expected 0000", rsp_a); end
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL drop_grant: got %b expected 0000", grant_a); end
        tick();
        rdvalid = 1'b0;
        #1;
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL drop_after_grant: got %b expected 0000", grant_a); end
        req_valid = '0;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (grant_a !== 4'(1 << k)) begin n_fail++; $display("FAIL same_fill_grant%0d: got %b expected %b", k, grant_a, 4'(1 << k)); end
            tick();
        end
        rdvalid  = 1'b1;
        rx_mdata = 16'd0;
        #1;
        n_checks++; if (grant_a !== 4'b1000) begin n_fail++; $display("FAIL same_grant: got %b expected 1000", grant_a); end
        n_checks++; if (rsp_a !== 4'b0001) begin n_fail++; $display("FAIL same_rsp: got %b expected 0001", rsp_a); end
        tick();
        rdvalid = 1'b0;
        #1;
        n_checks++; if (grant_a !== 4'b0001) begin n_fail++; $display("FAIL same_at3_grant: got %b expected 0001", grant_a); end
        tick();
        #1;
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL same_at4_grant: got %b expected 0000", grant_a); end
        req_valid = '0;
    endtask

    task automatic test_withdraw();
        apply_reset();
        almfull   = 1'b1;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        almfull   = 1'b0;
        #1;
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL withdraw_grant: got %b expected 0000", grant_a); end
        tick();
        n_checks++; if (tx_valid_a !== 1'b0) begin n_fail++; $display("FAIL withdraw_txvalid: got %b expected 0", tx_valid_a); end
        req_valid = 4'b0100;
        #1;
        n_checks++; if (grant_a !== 4'b0100) begin n_fail++; $display("FAIL withdraw_next_grant: got %b expected 0100", grant_a); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_flush();
        apply_reset();
        req_valid = 4'b0011;
        #1;
        n_checks++; if (grant_a !== 4'b0001) begin n_fail++; $display("FAIL flush_pre_grant0: got %b expected 0001", grant_a); end
        tick();
        #1;
        n_checks++; if (grant_a !== 4'b0010) begin n_fail++; $display("FAIL flush_pre_grant1: got %b expected 0010", grant_a); end
        tick();
        req_valid = '0;
        flush     = 1'b1;
        tick();
        req_valid = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL flush_drain_grant%0d: got %b expected 0000", k, grant_a); end
            n_checks++; if (fdone_a !== 1'b0) begin n_fail++; $display("FAIL flush_drain_done%0d: got %b expected 0", k, fdone_a); end
            tick();
        end
        rdvalid  = 1'b1;
        rx_mdata = 16'd0;
        #1;
        n_checks++; if (rsp_a !== 4'b0001) begin n_fail++; $display("FAIL flush_rsp0: got %b expected 0001", rsp_a); end
        tick();
        rx_mdata = 16'd1;
        #1;
        n_checks++; if (rsp_a !== 4'b0010) begin n_fail++; $display("FAIL flush_rsp1: got %b expected 0010", rsp_a); end
        n_checks++; if (fdone_a !== 1'b0) begin n_fail++; $display("FAIL flush_done_early: got %b expected 0", fdone_a); end
        tick();
        rdvalid = 1'b0;
        #1;
        n_checks++; if (fdone_a !== 1'b1) begin n_fail++; $display("FAIL flush_done: got %b expected 1", fdone_a); end
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL flush_done_grant: got %b expected 0000", grant_a); end
        tick();
        flush = 1'b0;
        #1;
        n_checks++; if (fdone_a !== 1'b1) begin n_fail++; $display("FAIL flush_hold_done: got %b expected 1", fdone_a); end
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL flush_hold_grant: got %b expected 0000", grant_a); end
        tick();
        #1;
        n_checks++; if (fdone_a !== 1'b0) begin n_fail++; $display("FAIL flush_run_done: got %b expected 0", fdone_a); end
        n_checks++; if (grant_a !== 4'b0100) begin n_fail++; $display("FAIL flush_run_grant: got %b expected 0100", grant_a); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = 4'b1111;
        #1;
        n_checks++; if (grant_a !== 4'b0001) begin n_fail++; $display("FAIL mid_grant0: got %b expected 0001", grant_a); end
        tick();
        #1;
        n_checks++; if (grant_a !== 4'b0010) begin n_fail++; $display("FAIL mid_grant1: got %b expected 0010", grant_a); end
        tick();
        rdvalid  = 1'b1;
        rx_mdata = 16'd3;
        reset_n  = 1'b0;
        #1;
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_grant: got %b expected 0000", grant_a); end
        n_checks++; if (tx_valid_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_txvalid: got %b expected 0", tx_valid_a); end
        n_checks++; if (rsp_a !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_rsp: got %b expected 0000", rsp_a); end
        n_checks++; if (fdone_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fdone: got %b expected 0", fdone_a); end
        n_checks++; if (tx_valid_b !== 1'b0) begin n_fail++; $display("FAIL mid_rst_txvalid_b: got %b expected 0", tx_valid_b); end
        tick();
        reset_n   = 1'b1;
        req_valid = '0;
        rx_mdata  = 16'd1;
        #1;
        n_checks++; if (rsp_a !== 4'b0010) begin n_fail++; $display("FAIL mid_stray_rsp: got %b expected 0010", rsp_a); end
        tick();
        rdvalid   = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (grant_a !== 4'(1 << k)) begin n_fail++; $display("FAIL mid_refill_grant%0d: got %b expected %b", k, grant_a, 4'(1 << k)); end
            tick();
        end
        #1;
        n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL mid_refill_full: got %b expected 0000", grant_a); end
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_addr[i] = 42'h155_5555_5500 + 42'(i * 64);
        test_reset();
        test_round_robin();
        test_almfull();
        test_max_outstanding();
        test_same_cycle();
        test_withdraw();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hc_rd_arbiter.md
HC_RD_ARBITER -- requirements
Module: hc_rd_arbiter

Interface
REQ-001 SHALL take parameter N_REQ, default 4, meaning number of read requesters (2..8).
REQ-002 SHALL take parameter MAX_OUTSTANDING, default 64, meaning maximum in-flight c0 read requests (power of two, ≤256).
REQ-003 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, N_REQ, meaning requester i has a read pending.
REQ-006 SHALL have port req_addr, input, N_REQ x 42, meaning the cache-line address per requester.
REQ-007 SHALL have port req_grant, output, N_REQ, meaning one-hot acceptance of requester i's request this cycle.
REQ-008 SHALL have ports c0_tx_valid (output, 1), c0_tx_addr (output, 42) and c0_tx_mdata (output, 16), meaning the CCI-P c0 read request.
REQ-009 SHALL have port c0_tx_almfull, input, 1, meaning the c0TxAlmFull back-pressure signal.
REQ-010 SHALL have ports c0_rx_rdvalid (input, 1) and c0_rx_mdata (input, 16), meaning a read response arrived.
REQ-011 SHALL have port rsp_valid, output, N_REQ, meaning the response is routed to requester i.
REQ-012 SHALL have ports flush (input, 1) and flush_done (output, 1), meaning a drain request and its completion.

Function
REQ-013 SHALL arbitrate round-robin: grant the first requester with req_valid set at or after rr_ptr, wrapping; on grant, rr_ptr becomes grant index + 1 mod N_REQ.
REQ-014 SHALL grant only when state is RUN, c0_tx_almfull=0 and outstanding<MAX_OUTSTANDING; at most one grant per cycle.
REQ-015 SHALL register the issue: the cycle after grant, c0_tx_valid=1, c0_tx_addr=granted addr, c0_tx_mdata={zeros, grant index}; c0_tx_valid is otherwise 0.
REQ-016 SHALL increment outstanding on grant and decrement it on c0_rx_rdvalid; when both occur in the same cycle, outstanding SHALL be unchanged.
REQ-017 SHALL assert rsp_valid[c0_rx_mdata[2:0]] combinationally with c0_rx_rdvalid; mdata index ≥N_REQ SHALL be dropped without decrementing outstanding.
REQ-018 SHALL implement FSM RUN -> DRAIN on flush=1; DRAIN -> DONE when outstanding==0 and c0_tx_valid==0; DONE -> RUN when flush=0.
REQ-019 SHALL assert flush_done=1 only in DONE; grants SHALL be suppressed in DRAIN and DONE.
REQ-020 SHALL never underflow outstanding: a decrement at 0 SHALL saturate at 0.
REQ-021 SHALL let a requester keep req_valid held until granted; deasserting req_valid before the grant SHALL withdraw the request without error.

Reset
REQ-022 SHALL on reset_n=0 asynchronously clear state to RUN, rr_ptr to 0, outstanding to 0, and drive req_grant, c0_tx_valid, rsp_valid and flush_done to 0.
REQ-023 SHALL, when reset is asserted mid-operation, discard in-flight accounting; responses arriving after release SHALL still route via rsp_valid but SHALL NOT decrement below 0.

Configuration
REQ-024 SHALL, when HC_RD_ARB_STATS_EN is defined, add output grant_count (N_REQ x 32): per-requester saturating grant counters, reset to 0.
REQ-025 SHALL, when HC_RD_ARB_STATS_EN is undefined, omit grant_count and its counters entirely.

Structure
REQ-026 SHALL place the 42-bit address typedef, the 16-bit mdata typedef and the arbiter state enum in hc_pkg.
REQ-027 SHALL implement the round-robin pick in a sub-module, hc_rr_pick (N-bit request and pointer in, one-hot grant out, purely combinational).

Verification
REQ-028 SHALL cover: req_valid=4'b1111 held, no almfull -> grants 0,1,2,3,0 in consecutive cycles; c0_tx_mdata=0,1,2,3,0 one cycle later.
REQ-029 SHALL cover: c0_tx_almfull=1 for 5 cycles with req_valid=4'b0001 -> no grant in those cycles; grant the cycle almfull falls.
REQ-030 SHALL cover: MAX_OUTSTANDING=4, 4 grants with no responses -> no 5th grant; one response (mdata=2) -> rsp_valid=4'b0100 and a grant the same cycle.
REQ-031 SHALL cover: a grant and a response in the same cycle at outstanding=3 -> outstanding stays 3.
REQ-032 SHALL cover: flush with 2 outstanding -> grants stop, flush_done=1 the cycle after the 2nd response; flush=0 -> RUN the next cycle.
REQ-033 SHALL cover: reset_n pulsed low mid-burst -> all outputs 0 immediately; after release, a stray response leaves outstanding at 0.
